elevator_dispatch: RTL and testbench

Request dispatcher sitting directly upstream of the elevator car controller. Accepts (origin, destination) floor requests over a valid/ready handshake, validates and buffers them in a FIFO, and issues them one at a time to the car controller via its `en`/`in_origin`/`destination` inputs. It then tracks completion through the controller's `idle` output. `destination` is held stable for the whole trip, because the car controller samples it continuously rather than latching it.

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elev_req_fifo.sv | 76 +++++++
 rtl/elevator_dispatch.sv | 126 ++++++++++++
 tb/tb_elevator_dispatch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types for the elevator request dispatcher: floor encoding, FSM states
// and the queued (origin, dest) request record.
package elevator_pkg;

  typedef logic [2:0] floor_t;

  localparam int NUM_FLOORS_DEF = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    BUSY     = 2'd3
  } dispatch_state_t;

  typedef struct packed {
    floor_t origin;
    floor_t dest;
  } req_t;

endpackage

// File: rtl/elev_req_fifo.sv
// Request FIFO; head entry is visible until popped. With ELEV_REQ_DEDUP_EN the
// match output flags any valid entry equal to the incoming request.
module elev_req_fifo
  import elevator_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  req_t                       din,
  output req_t                       head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ELEV_REQ_DEDUP_EN
  ,
  output logic                       match
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  req_t          mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

`ifdef ELEV_REQ_DEDUP_EN
  // Per-entry valid bits so stale storage never produces a false match.
  logic [DEPTH-1:0] vld, hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld <= '0;
    end else begin
      if (do_pop)  vld[rd_ptr] <= 1'b0;
      if (do_push) vld[wr_ptr] <= 1'b1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign hit[i] = vld[i] && (mem[i] == din);
  end

  assign match = |hit;
`endif

endmodule

// File: rtl/elevator_dispatch.sv
// Elevator request dispatcher: validates and queues floor requests, issues them
// one trip at a time to the car controller. Optional dedup: ELEV_REQ_DEDUP_EN.
module elevator_dispatch
  import elevator_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 8,
  parameter int NUM_FLOORS  = NUM_FLOORS_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  input  logic [2:0]                 req_origin,
  input  logic [2:0]                 req_dest,
  output logic                       req_ready,
  output logic                       req_error,
  input  logic                       elev_idle,
  output logic                       elev_en,
  output logic [2:0]                 elev_origin,
  output logic [2:0]                 elev_dest,
  output logic                       busy,
  output logic                       dispatch_timeout,
  output logic [$clog2(DEPTH+1)-1:0] q_count
`ifdef ELEV_REQ_DEDUP_EN
  ,
  output logic                       dedup_hit
`endif
);

  localparam int         TW   = $clog2(ACK_TIMEOUT+1);
  localparam logic [3:0] NF   = 4'(NUM_FLOORS);
  localparam logic [TW-1:0] LAST = TW'(ACK_TIMEOUT-1);

  dispatch_state_t state, state_n;
  logic [TW-1:0]   cnt;
  req_t            head, in_req;
  logic            full, empty, accept, bad, push, pop, timeout;

  assign in_req    = '{origin: req_origin, dest: req_dest};
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign bad       = ({1'b0, req_origin} >= NF) || ({1'b0, req_dest} >= NF) ||
                     (req_origin == req_dest);

`ifdef ELEV_REQ_DEDUP_EN
  logic match, dup;
  // The in-flight trip has already left the queue, so compare it separately.
  assign dup  = match || (state == BUSY && elev_origin == req_origin && elev_dest == req_dest);
  assign push = accept && !bad && !dup;
`else
  assign push = accept && !bad;
`endif

  elev_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (in_req),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
`ifdef ELEV_REQ_DEDUP_EN
    ,
    .match (match)
`endif
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE:     if (!empty && elev_idle) state_n = ISSUE;
      ISSUE:    state_n = WAIT_ACK;
      WAIT_ACK: begin
        if (!elev_idle) begin
          state_n = BUSY;
          pop     = 1'b1;
        end else if (cnt == LAST) begin
          state_n = IDLE;
          timeout = 1'b1;
        end
      end
      BUSY:     if (elev_idle) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Outputs are registered off the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt              <= '0;
      elev_en          <= 1'b0;
      elev_origin      <= '0;
      elev_dest        <= '0;
      busy             <= 1'b0;
      dispatch_timeout <= 1'b0;
      req_error        <= 1'b0;
`ifdef ELEV_REQ_DEDUP_EN
      dedup_hit        <= 1'b0;
`endif
    end else begin
      elev_en          <= (state_n == ISSUE);
      busy             <= (state_n == BUSY);
      dispatch_timeout <= timeout;
      req_error        <= accept && bad;
`ifdef ELEV_REQ_DEDUP_EN
      dedup_hit        <= accept && !bad && dup;
`endif
      if (state == ISSUE)         cnt <= '0;
      else if (state == WAIT_ACK) cnt <= cnt + 1'b1;
      if (state == IDLE && state_n == ISSUE) begin
        elev_origin <= head.origin;
        elev_dest   <= head.dest;
      end
    end
  end

endmodule

// File: tb/tb_elevator_dispatch.sv
// Directed bench for elevator_dispatch: validation table plus hand-timed
// sequences for dispatch latency, FIFO order, ack timeout, reset and dedup.
module tb_elevator_dispatch;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_origin, req_dest;
  logic       req_ready, req_error;
  logic       elev_idle, elev_en;
  logic [2:0] elev_origin, elev_dest;
  logic       busy, dispatch_timeout;
  logic [2:0] q_count;
`ifdef ELEV_REQ_DEDUP_EN
  logic       dedup_hit;
`endif

  int tests = 0;
  int fails = 0;

  // Car model: drops idle one cycle after sampling en, trip lasts a few cycles.
  logic car_auto = 1'b0;
  logic man_idle = 1'b0;
  logic car_idle = 1'b1;
  int   trip_left = 0;
  assign elev_idle = car_auto ? car_idle : man_idle;

  always #5 clk = ~clk;

  elevator_dispatch dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_origin       (req_origin),
    .req_dest         (req_dest),
    .req_ready        (req_ready),
    .req_error        (req_error),
    .elev_idle        (elev_idle),
    .elev_en          (elev_en),
    .elev_origin      (elev_origin),
    .elev_dest        (elev_dest),
    .busy             (busy),
    .dispatch_timeout (dispatch_timeout),
    .q_count          (q_count)
`ifdef ELEV_REQ_DEDUP_EN
    ,
    .dedup_hit        (dedup_hit)
`endif
  );

  always @(posedge clk) begin
    if (!car_auto) begin
      car_idle  <= 1'b1;
      trip_left <= 0;
    end else if (trip_left != 0) begin
      trip_left <= trip_left - 1;
      if (trip_left == 1) car_idle <= 1'b1;
    end else if (elev_en === 1'b1) begin
      car_idle  <= 1'b0;
      trip_left <= 4;
    end
  end

  // Log every issue and count BUSY cycles whose trip values drift.
  logic [2:0] log_o [64];
  logic [2:0] log_d [64];
  int n_disp   = 0;
  int hold_err = 0;
  always @(posedge clk) begin
    if (elev_en === 1'b1 && n_disp < 64) begin
      log_o[n_disp] <= elev_origin;
      log_d[n_disp] <= elev_dest;
      n_disp        <= n_disp + 1;
    end
    if (busy === 1'b1 && n_disp > 0 &&
        (elev_origin !== log_o[n_disp-1] || elev_dest !== log_d[n_disp-1]))
      hold_err <= hold_err + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [2:0] d);
    req_valid  = 1'b1;
    req_origin = o;
    req_dest   = d;
    tick();
    req_valid  = 1'b0;
  endtask

  typedef struct {
    logic [2:0] o;
    logic [2:0] d;
    logic       err;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int base, k;
    logic [2:0] exp_o [5];
    logic [2:0] exp_d [5];

    tbl[0] = '{o: 3'd5, d: 3'd2, err: 1'b1, cnt: 3'd0};
    tbl[1] = '{o: 3'd3, d: 3'd3, err: 1'b1, cnt: 3'd0};
    tbl[2] = '{o: 3'd7, d: 3'd0, err: 1'b1, cnt: 3'd0};
    tbl[3] = '{o: 3'd0, d: 3'd5, err: 1'b1, cnt: 3'd0};
    tbl[4] = '{o: 3'd4, d: 3'd4, err: 1'b1, cnt: 3'd0};
    exp_o = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    exp_d = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd2};

    reset = 1'b0; req_valid = 1'b0; req_origin = '0; req_dest = '0;
    repeat (3) tick();
    chk("rst_ready",   req_ready, 1);
    chk("rst_error",   req_error, 0);
    chk("rst_en",      elev_en, 0);
    chk("rst_origin",  elev_origin, 0);
    chk("rst_dest",    elev_dest, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_timeout", dispatch_timeout, 0);
    chk("rst_count",   q_count, 0);
    reset = 1'b1;
    man_idle = 1'b1;
    tick();

    // Validation table: every entry is rejected with a one-cycle error pulse.
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].o, tbl[i].d);
      chk($sformatf("vec%0d_error", i), req_error, tbl[i].err);
      chk($sformatf("vec%0d_count", i), q_count, tbl[i].cnt);
      tick();
      chk($sformatf("vec%0d_error_drop", i), req_error, 0);
      chk($sformatf("vec%0d_en", i), elev_en, 0);
    end
    chk("invalid_no_dispatch", n_disp, 0);

    // Single request: en two cycles after accept, values held through BUSY.
    send(3'd1, 3'd4);
    chk("single_en_early", elev_en, 0);
    chk("single_count", q_count, 1);
    tick();
    chk("single_en", elev_en, 1);
    chk("single_origin", elev_origin, 1);
    chk("single_dest", elev_dest, 4);
    tick();
    chk("single_en_pulse", elev_en, 0);
    man_idle = 1'b0;
    tick();
    chk("single_busy", busy, 1);
    chk("single_popped", q_count, 0);
    repeat (3) tick();
    chk("single_busy_hold", busy, 1);
    chk("single_origin_hold", elev_origin, 1);
    chk("single_dest_hold", elev_dest, 4);
    man_idle = 1'b1;
    tick();
    chk("single_done", busy, 0);
    chk("single_origin_kept", elev_origin, 1);
    chk("single_one_issue", n_disp, 1);

    // Four requests queued behind a running trip, then drained in order.
    car_auto = 1'b1;
    tick();
    base = n_disp;
    send(exp_o[0], exp_d[0]);
    for (int i = 1; i < 5; i++) send(exp_o[i], exp_d[i]);
    chk("full_count", q_count, 4);
    chk("full_ready", req_ready, 0);
    send(3'd0, 3'd1);
    chk("full_no_push", q_count, 4);
    k = 0;
    while (n_disp < base + 5 && k < 200) begin tick(); k++; end
    chk("order_timeout", (k < 200), 1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("order%0d_origin", i), log_o[base+i], exp_o[i]);
      chk($sformatf("order%0d_dest", i), log_d[base+i], exp_d[i]);
    end
    k = 0;
    while ((busy !== 1'b0 || q_count != 0) && k < 200) begin tick(); k++; end
    chk("drain", (k < 200), 1);
    repeat (3) tick();
    chk("drain_issues", n_disp, base + 5);

    // Ack timeout: car never drops idle, head retained and reissued.
    car_auto = 1'b0;
    man_idle = 1'b1;
    tick();
    base = n_disp;
    send(3'd2, 3'd3);
    tick();
    chk("to_en", elev_en, 1);
    tick();
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("to_wait%0d", i), dispatch_timeout, 0);
    end
    tick();
    chk("to_pulse", dispatch_timeout, 1);
    chk("to_count", q_count, 1);
    chk("to_en_low", elev_en, 0);
    tick();
    chk("to_pulse_drop", dispatch_timeout, 0);
    chk("to_reissue", elev_en, 1);
    chk("to_origin", elev_origin, 2);
    chk("to_dest", elev_dest, 3);
    chk("to_reissue_count", q_count, 1);
    tick();
    man_idle = 1'b0;
    tick();
    chk("to_busy", busy, 1);
    chk("to_popped", q_count, 0);
    man_idle = 1'b1;
    tick();
    chk("to_done", busy, 0);
    chk("to_issues", n_disp, base + 2);

    // Reset mid-trip with two requests still queued.
    car_auto = 1'b1;
    tick();
    send(3'd0, 3'd1);
    send(3'd1, 3'd2);
    send(3'd2, 3'd3);
    tick();
    chk("mid_busy", busy, 1);
    chk("mid_count", q_count, 2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mid_rst_count", q_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", elev_en, 0);
    base = n_disp;
    repeat (10) tick();
    chk("mid_no_dispatch", n_disp, base);

    // Duplicate requests while the car is unavailable.
    car_auto = 1'b0;
    man_idle = 1'b0;
    tick();
    send(3'd0, 3'd3);
`ifdef ELEV_REQ_DEDUP_EN
    chk("dup_first_hit", dedup_hit, 0);
`endif
    send(3'd0, 3'd3);
`ifdef ELEV_REQ_DEDUP_EN
    chk("dup_hit", dedup_hit, 1);
    chk("dup_count", q_count, 1);
    tick();
    chk("dup_hit_drop", dedup_hit, 0);
`else
    chk("dup_count", q_count, 2);
    tick();
`endif
    repeat (3) tick();
    chk("gate_no_en", elev_en, 0);
    chk("gate_no_dispatch", n_disp, base);
    chk("hold_stable", hold_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
